// File: rtl/aes_round_sequencer_if.sv
// Bus bundle for the AES round sequencer.
// Groups the byte-serial load/unload stream and the round-datapath handshake.
//   slave  : the sequencer (consumes bytes and datapath results, drives
//            load/ready, round launch, ciphertext stream and err)
//   master : the environment (byte source/sink and the shared round datapath)
interface aes_round_sequencer_if;
   logic         enable;
   logic         in_valid;
   logic [7:0]   key_byte;
   logic [7:0]   state_byte;
   logic         load;
   logic         ready;
   logic         dp_start;
   logic [3:0]   dp_round;
   logic         dp_last;
   logic [127:0] dp_state;
   logic [127:0] dp_key;
   logic [127:0] dp_state_in;
   logic [127:0] dp_key_in;
   logic         dp_done;
   logic         out_valid;
   logic [7:0]   state_out_byte;
   logic         err;

   modport slave (
      input  enable, in_valid, key_byte, state_byte,
      input  dp_state_in, dp_key_in, dp_done,
      output load, ready, dp_start, dp_round, dp_last, dp_state, dp_key,
      output out_valid, state_out_byte, err
   );

   modport master (
      output enable, in_valid, key_byte, state_byte,
      output dp_state_in, dp_key_in, dp_done,
      input  load, ready, dp_start, dp_round, dp_last, dp_state, dp_key,
      input  out_valid, state_out_byte, err
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller.
// Loads key and plaintext byte-serially (MSB first), applies the initial
// AddRoundKey, drives one shared external round datapath through rounds
// 1..NUM_ROUNDS and streams the ciphertext out byte-serially.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of aes_round_sequencer_if
//              (enable/in_valid/key_byte/state_byte in, load/ready out,
//               dp_start/dp_round/dp_last/dp_state/dp_key out,
//               dp_state_in/dp_key_in/dp_done in,
//               out_valid/state_out_byte/err out)
module aes_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned WAIT_LIMIT = 64
) (
   input logic                  clk,
   input logic                  rst,
   aes_round_sequencer_if.slave bus
);

   localparam int unsigned WAIT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, ARK0, ISSUE, WAIT, OUTPUT} state_t;

   state_t              state;
   logic [127:0]        key_r;
   logic [127:0]        state_r;
   logic [3:0]          byte_cnt;
   logic [3:0]          round_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [6:0]          byte_lsb;
   logic                accept;

   // Byte n (MSB first) sits at bits [127-8n -: 8], i.e. LSB index 8*(15-n).
   assign byte_lsb = {~byte_cnt, 3'b000};
   assign accept   = bus.enable & bus.in_valid;

   // Datapath operands come straight from the working registers, which are
   // only rewritten on dp_done, so they stay stable for the whole round.
   assign bus.dp_state = state_r;
   assign bus.dp_key   = key_r;

   // Ciphertext stream: enable-qualified valid, byte selected by byte_cnt.
   assign bus.out_valid      = (state == OUTPUT) & bus.enable;
   assign bus.state_out_byte = (state == OUTPUT) ? state_r[byte_lsb +: 8] : 8'h00;

   // Sequencer FSM with registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         key_r        <= '0;
         state_r      <= '0;
         byte_cnt     <= '0;
         round_cnt    <= '0;
         wait_cnt     <= '0;
         bus.load     <= 1'b1;
         bus.ready    <= 1'b1;
         bus.dp_start <= 1'b0;
         bus.dp_round <= '0;
         bus.dp_last  <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.dp_start <= 1'b0;
         bus.err      <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  key_r[127:120]   <= bus.key_byte;
                  state_r[127:120] <= bus.state_byte;
                  byte_cnt         <= 4'd1;
                  bus.ready        <= 1'b0;
                  state            <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  key_r[byte_lsb +: 8]   <= bus.key_byte;
                  state_r[byte_lsb +: 8] <= bus.state_byte;
                  byte_cnt               <= byte_cnt + 4'd1;
                  if (byte_cnt == 4'd15) begin
                     bus.load <= 1'b0;
                     state    <= ARK0;
                  end
               end
            end
            ARK0: begin
               state_r      <= state_r ^ key_r;
               round_cnt    <= 4'd1;
               bus.dp_start <= 1'b1;
               bus.dp_round <= 4'd1;
               bus.dp_last  <= (NUM_ROUNDS == 1);
               state        <= ISSUE;
            end
            ISSUE: begin
               wait_cnt    <= '0;
               bus.dp_last <= 1'b0;
               state       <= WAIT;
            end
            WAIT: begin
               if (bus.dp_done) begin
                  state_r <= bus.dp_state_in;
                  key_r   <= bus.dp_key_in;
                  if (round_cnt == 4'(NUM_ROUNDS)) begin
                     byte_cnt <= '0;
                     state    <= OUTPUT;
                  end else begin
                     round_cnt    <= round_cnt + 4'd1;
                     bus.dp_start <= 1'b1;
                     bus.dp_round <= round_cnt + 4'd1;
                     bus.dp_last  <= ((round_cnt + 4'd1) == 4'(NUM_ROUNDS));
                     state        <= ISSUE;
                  end
               end else if (wait_cnt == WAIT_W'(WAIT_LIMIT - 2)) begin
                  // Counter would reach WAIT_LIMIT-1: abandon the block.
                  key_r        <= '0;
                  state_r      <= '0;
                  byte_cnt     <= '0;
                  round_cnt    <= '0;
                  wait_cnt     <= '0;
                  bus.dp_round <= '0;
                  bus.load     <= 1'b1;
                  bus.ready    <= 1'b1;
                  bus.err      <= 1'b1;
                  state        <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            OUTPUT: begin
               if (bus.enable) begin
                  byte_cnt <= byte_cnt + 4'd1;
                  if (byte_cnt == 4'd15) begin
                     bus.load  <= 1'b1;
                     bus.ready <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer.
// A behavioural AES round model answers dp_start with configurable latency;
// expected ciphertexts are the published FIPS-197 vectors.
// Ports: none (top-level bench).
module tb_aes_round_sequencer;

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ARK1 = 128'h00102030405060708090a0b0c0d0e0f0;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // Datapath model controls
   int           lat = 1;
   int           mode = 0;        // 0: real AES round, 1: pass-through
   int           drop_round = 0;  // round that never gets dp_done (0: none)
   int           next_round = 1;
   int           start_cyc = 0;
   int           cnt = 0;
   logic [127:0] res_s, res_k, cap_s;

   aes_round_sequencer_if bus ();

   aes_round_sequencer #(.NUM_ROUNDS(10), .WAIT_LIMIT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- AES reference round ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] v);
      logic [7:0] inv, base, r, s;
      inv = 8'h01; base = v;
      for (int i = 1; i < 8; i++) begin
         base = gmul(base, base);
         inv  = gmul(inv, base);
      end
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input int rnd);
      logic [31:0] w0, w1, w2, w3, rot, tmp;
      logic [7:0]  rc;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      rot = {w3[23:0], w3[31:24]};
      tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      rc = 8'h01;
      for (int j = 1; j < rnd; j++) rc = xt(rc);
      tmp[31:24] = tmp[31:24] ^ rc;
      w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r) % 4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ rk;
   endfunction

   // ---------------- Datapath responder ----------------
   initial begin
      bus.dp_done = 1'b0; bus.dp_state_in = '0; bus.dp_key_in = '0;
      forever begin
         @(negedge clk);
         bus.dp_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.dp_done = 1'b1;
               bus.dp_state_in = res_s;
               bus.dp_key_in = res_k;
               if (rst === 1'b0) check("dp_state_held", bus.dp_state, cap_s);
            end
         end
         if (bus.dp_start === 1'b1 && rst === 1'b0) begin
            check("dp_round", 128'(bus.dp_round), 128'(next_round));
            check("dp_last", 128'(bus.dp_last), 128'(next_round == 10));
            start_cyc = cyc;
            cap_s = bus.dp_state;
            if (next_round != drop_round) begin
               if (mode == 1) begin
                  res_s = bus.dp_state;
                  res_k = bus.dp_key;
               end else begin
                  res_k = next_key(bus.dp_key, next_round);
                  res_s = aes_round(bus.dp_state, res_k, next_round == 10);
               end
               cnt = lat;
            end
            next_round++;
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic send_block(input logic [127:0] k, input logic [127:0] p, input bit toggle,
                             output int t_last);
      t_last = 0;
      for (int i = 0; i < 16; i++) begin
         if (toggle) begin
            bus.enable = 1'b0; bus.in_valid = 1'b1;
            bus.key_byte = 8'hff; bus.state_byte = 8'hee;
            @(negedge clk);
         end
         bus.enable = 1'b1; bus.in_valid = 1'b1;
         bus.key_byte = k[127-8*i -: 8]; bus.state_byte = p[127-8*i -: 8];
         #1;
         check("load_hi", 128'(bus.load), 128'(1));
         t_last = cyc;
         @(negedge clk);
      end
      bus.in_valid = 1'b0; bus.key_byte = 8'h00; bus.state_byte = 8'h00;
   endtask

   task automatic recv_block(input bit toggle, input bit noise, output logic [127:0] ct,
                             output int first_c, output int last_c);
      int         n;
      logic [7:0] held;
      ct = '0; first_c = -1; last_c = -1;
      bus.enable = 1'b1; bus.in_valid = noise;
      bus.key_byte = 8'h5a; bus.state_byte = 8'ha5;
      #1;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 400) begin
         @(negedge clk); #1; n++;
      end
      check("out_valid_seen", 128'(bus.out_valid), 128'(1));
      if (bus.out_valid !== 1'b1) return;
      first_c = cyc;
      for (int i = 0; i < 16; i++) begin
         if (!toggle && i > 0) check("out_valid_step", 128'(bus.out_valid), 128'(1));
         ct[127-8*i -: 8] = bus.state_out_byte;
         last_c = cyc;
         @(negedge clk);
         if (toggle && i < 15) begin
            bus.enable = 1'b0; #1;
            check("hold_valid_low", 128'(bus.out_valid), 128'(0));
            held = bus.state_out_byte;
            @(negedge clk);
            bus.enable = 1'b1; #1;
            check("hold_byte", 128'(bus.state_out_byte), 128'(held));
         end else if (i < 15) begin
            #1;
         end
      end
   endtask

   // ---------------- Directed sequence ----------------
   initial begin
      logic [127:0] ct;
      int           t, f, l, n, n_err, err_cyc, ov, rdy;

      rst = 1'b1;
      bus.enable = 1'b0; bus.in_valid = 1'b0; bus.key_byte = 8'h00; bus.state_byte = 8'h00;
      @(negedge clk); @(negedge clk); #1;
      check("rst_ctrl", 128'({bus.load, bus.ready, bus.dp_start, bus.dp_round, bus.dp_last,
                              bus.out_valid, bus.state_out_byte, bus.err}),
            128'({1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0}));
      check("rst_dp_state", bus.dp_state, 128'h0);
      check("rst_dp_key", bus.dp_key, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // 1: FIPS-197 C.1, latency 1
      mode = 0; lat = 1; next_round = 1;
      send_block(KEY1, PT1, 1'b0, t);
      recv_block(1'b0, 1'b0, ct, f, l);
      check("c1_ct", ct, CT1);
      check("c1_first_lat", 128'(f - t), 128'(22));
      check("c1_last_lat", 128'(l - t), 128'(37));
      check("c1_rounds", 128'(next_round), 128'(11));
      #1;
      check("c1_ready", 128'(bus.ready), 128'(1));

      // 2: pass-through datapath exposes the initial AddRoundKey
      mode = 1; lat = 1; next_round = 1;
      send_block(KEY1, PT1, 1'b0, t);
      recv_block(1'b0, 1'b0, ct, f, l);
      check("ark0_ct", ct, ARK1);
      #1;

      // 3: enable toggling, latency 3
      mode = 0; lat = 3; next_round = 1;
      send_block(KEY1, PT1, 1'b1, t);
      recv_block(1'b1, 1'b0, ct, f, l);
      check("tog_ct", ct, CT1);
      check("tog_first_lat", 128'(f - t), 128'(42));
      #1;
      check("tog_ready", 128'(bus.ready), 128'(1));

      // 4: datapath never answers round 4
      lat = 1; drop_round = 4; next_round = 1;
      send_block(KEY2, PT2, 1'b0, t);
      bus.enable = 1'b1;
      n_err = 0; err_cyc = -10; ov = 0; rdy = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk); #1;
         if (bus.err === 1'b1) begin n_err++; err_cyc = cyc; end
         if (bus.out_valid === 1'b1) ov++;
         if (cyc == err_cyc + 1) rdy = int'(bus.ready);
      end
      check("to_err_count", 128'(n_err), 128'(1));
      check("to_err_time", 128'(err_cyc - start_cyc), 128'(64));
      check("to_no_output", 128'(ov), 128'(0));
      check("to_ready_next", 128'(rdy), 128'(1));
      check("to_rounds", 128'(next_round), 128'(5));
      drop_round = 0;

      // 5: reset during round 6 WAIT, then a clean block
      lat = 3; next_round = 1;
      send_block(KEY1, PT1, 1'b0, t);
      n = 0; #1;
      while (!(bus.dp_start === 1'b1 && bus.dp_round == 4'd6) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      check("rst6_found", 128'(bus.dp_start), 128'(1));
      check("rst6_pre_state", 128'(bus.dp_state != 128'h0), 128'(1));
      @(negedge clk);
      rst = 1'b1; #1;
      check("rst6_ctrl", 128'({bus.load, bus.ready, bus.dp_start, bus.dp_round, bus.dp_last,
                               bus.out_valid, bus.state_out_byte, bus.err}),
            128'({1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0}));
      check("rst6_dp_state", bus.dp_state, 128'h0);
      check("rst6_dp_key", bus.dp_key, 128'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      lat = 1; next_round = 1;
      @(negedge clk);
      send_block(KEY2, PT2, 1'b0, t);
      recv_block(1'b0, 1'b0, ct, f, l);
      check("post_rst_ct", ct, CT2);
      #1;

      // 6: back-to-back blocks with in_valid noise during rounds
      lat = 1; next_round = 1;
      send_block(KEY1, PT1, 1'b0, t);
      recv_block(1'b0, 1'b1, ct, f, l);
      check("b2b_a_ct", ct, CT1);
      #1;
      check("b2b_ready", 128'(bus.ready), 128'(1));
      next_round = 1;
      send_block(KEY2, PT2, 1'b0, t);
      recv_block(1'b0, 1'b1, ct, f, l);
      check("b2b_b_ct", ct, CT2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, observed time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller. It collects key and plaintext byte-serially and performs the initial AddRoundKey internally. It then sequences a shared external round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey plus single-step key expansion) through rounds 1..NUM_ROUNDS, and streams the ciphertext back out byte-serially. One round datapath instance is reused for all rounds instead of unrolling ten stages.

Parameters:
NUM_ROUNDS, 10, number of datapath rounds; the final round has dp_last=1.
WAIT_LIMIT, 64, maximum cycles spent waiting for dp_done before an abort; must be at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
enable  in  1  gates byte transfers (input accept and output stepping)
in_valid  in  1  key_byte/state_byte valid this cycle
key_byte  in  8  key byte, MSB-first
state_byte  in  8  plaintext byte, MSB-first
load  out  1  sequencer is accepting input bytes
ready  out  1  idle, no block in flight
dp_start  out  1  one-cycle pulse: launch a round
dp_round  out  4  round number 1..NUM_ROUNDS, valid with dp_start
dp_last  out  1  final round (skip MixColumns), valid with dp_start
dp_state  out  128  state into datapath, held from dp_start to dp_done
dp_key  out  128  previous round key into datapath, held from dp_start to dp_done
dp_state_in  in  128  round result state
dp_key_in  in  128  expanded round key produced by the round
dp_done  in  1  result valid (single-cycle pulse)
out_valid  out  1  state_out_byte valid
state_out_byte  out  8  ciphertext byte, MSB-first
err  out  1  one-cycle pulse on datapath timeout

Behaviour:
- Reset values (asynchronous): state IDLE; key_r, state_r, byte_cnt, round_cnt, wait_cnt = 0; load=1, ready=1, dp_start=0, dp_round=0, dp_last=0, out_valid=0, state_out_byte=0, err=0. Reset mid-operation aborts the block with no output.
- States: IDLE, LOAD, ARK0, ISSUE, WAIT, OUTPUT.
- IDLE: load=1, ready=1. On enable&in_valid, capture the byte pair into bits [127:120], set byte_cnt=1, and go to LOAD.
- LOAD: load=1, ready=0. Each enable&in_valid cycle writes bits [127-8*byte_cnt -: 8] and increments byte_cnt. On acceptance of the 16th byte (byte_cnt=15), go to ARK0. in_valid is ignored when enable=0 and in all other states.
- ARK0: single cycle. state_r <= state_r ^ key_r; round_cnt <= 1; go to ISSUE.
- ISSUE: single cycle. dp_start=1, dp_round=round_cnt, dp_last=(round_cnt==NUM_ROUNDS). Clear wait_cnt; go to WAIT.
- WAIT: dp_state/dp_key are held stable. dp_done arriving in the ISSUE cycle is ignored; the earliest accepted dp_done is the first WAIT cycle.
  - On dp_done: state_r <= dp_state_in and key_r <= dp_key_in. If round_cnt==NUM_ROUNDS, go to OUTPUT with byte_cnt=0; otherwise round_cnt++ and go to ISSUE.
  - If wait_cnt reaches WAIT_LIMIT-1 without dp_done: pulse err for one cycle, go to IDLE, and clear the registers.
- Round sequencing is independent of enable.
- OUTPUT: out_valid=enable, state_out_byte=state_r[127-8*byte_cnt -: 8] (combinational from byte_cnt). Each enable cycle advances byte_cnt; after byte 15 is presented, go to IDLE and assert ready next cycle. enable=0 holds the current byte with out_valid=0.
- Latency with datapath latency L (dp_done L cycles after dp_start, L at least 1): last input byte at cycle T gives ARK0 at T+1 and the first out_valid at T+2+NUM_ROUNDS*(L+1). For L=1 that is T+22, and the last byte appears at T+37 with enable held high.
- Back-to-back blocks: a new block may start in the cycle after ready returns. No input buffering; bytes offered while load=0 are lost by contract.
- round_cnt never exceeds NUM_ROUNDS and never wraps.

Test Plan:
1. FIPS-197 C.1 vector, with the bench round model at L=1: key 000102..0f, plaintext 00112233..ff -> output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a. First out_valid 22 cycles after the last input byte; dp_round steps 1..10 and dp_last is set only on round 10.
2. ARK0 check: bench model returns dp_state unchanged and dp_key unchanged -> output equals plaintext^key, e.g. 00112233..ff ^ 000102..0f = 00102030..f0.
3. enable toggled every other cycle during LOAD and OUTPUT, with datapath latency L=3 -> same ciphertext as scenario 1; input bytes are taken only on enable-high cycles; each output byte is held while enable=0.
4. Timeout: bench withholds dp_done in round 4 -> err pulses exactly once, WAIT_LIMIT cycles after that round's dp_start; no out_valid; ready=1 on the next cycle.
5. rst asserted during round 6 WAIT -> outputs go to reset values immediately, with no clock edge needed. A subsequent full block produces the correct ciphertext.
6. Two back-to-back blocks, the second starting on the cycle after ready rises -> both ciphertexts correct, and in_valid pulses during the first block's rounds are ignored.
